// File: rtl/rr_arb_21.sv
// Purpose: two-requester packet arbiter. Round-robin between A and B at packet
//          granularity; a granted packet keeps the output until its last beat.
// Latency: 1 cycle from input acceptance to o_valid (single output register).
// Backpressure: requester ready only while the output slot is free
//               (!o_valid || i_ready); a held slot freezes data, state and ptr.
//
// Ports:
//   i_clk, i_rst                      clock, synchronous active-high reset
//   i_a_valid/i_a_data/i_a_last       requester A beat in,  o_a_ready back
//   i_b_valid/i_b_data/i_b_last       requester B beat in,  o_b_ready back
//   o_valid/o_data/o_last/o_src       output beat (o_src: 0 = A, 1 = B)
//   i_ready                           downstream accept
module rr_arb_21 #(
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_a_valid,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_last,
    output logic              o_a_ready,

    input  logic              i_b_valid,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_last,
    output logic              o_b_ready,

    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last,
    output logic              o_src,
    input  logic              i_ready
);

    // One beat as carried through the arbiter.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOCK_A = 2'd1;
    localparam logic [1:0] ST_LOCK_B = 2'd2;

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       ptr;        // last-served source: 0 = A, 1 = B
    logic       ptr_nxt;

    logic       slot_free;
    logic       grant_a;
    logic       grant_b;
    logic       take_a;
    logic       take_b;
    beat_t      beat_a;
    beat_t      beat_b;
    beat_t      beat_sel;

    // The output register can take a new beat if it is empty or is being
    // drained on this same edge.
    assign slot_free = !o_valid || i_ready;

    // Grant is derived only from state, ptr and the two valids so that the
    // ready outputs never see data or last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        case (state)
            ST_IDLE: begin
                // On a tie the source that was not served last wins.
                grant_a = i_a_valid && (!i_b_valid ||  ptr);
                grant_b = i_b_valid && (!i_a_valid || !ptr);
            end
            ST_LOCK_A: grant_a = 1'b1;
            ST_LOCK_B: grant_b = 1'b1;
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase
    end

    // Readies are forced low during reset so nothing is accepted on the
    // reset edge itself.
    assign o_a_ready = !i_rst && slot_free && grant_a;
    assign o_b_ready = !i_rst && slot_free && grant_b;

    assign take_a = i_a_valid && o_a_ready;
    assign take_b = i_b_valid && o_b_ready;

    assign beat_a   = '{last: i_a_last, data: i_a_data};
    assign beat_b   = '{last: i_b_last, data: i_b_data};
    assign beat_sel = take_b ? beat_b : beat_a;

    // Lock tracking: a non-final beat pins the arbiter to its source, the
    // final beat releases it and records who was served.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (take_a) begin
            if (i_a_last) begin
                state_nxt = ST_IDLE;
                ptr_nxt   = 1'b0;
            end else begin
                state_nxt = ST_LOCK_A;
            end
        end else if (take_b) begin
            if (i_b_last) begin
                state_nxt = ST_IDLE;
                ptr_nxt   = 1'b1;
            end else begin
                state_nxt = ST_LOCK_B;
            end
        end else if (state != ST_IDLE && state != ST_LOCK_A && state != ST_LOCK_B) begin
            // Unused encoding grants nobody; fall back to IDLE.
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            ptr     <= 1'b1;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_src   <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (take_a || take_b) begin
                o_valid <= 1'b1;
                o_data  <= beat_sel.data;
                o_last  <= beat_sel.last;
                o_src   <= take_b;
            end else if (i_ready) begin
                // Beat drained with nothing to replace it; data is left as is.
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rr_arb_21.sv
// Bench for rr_arb_21: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a packet-level model and a
// per-source scoreboard.
module tb_rr_arb_21;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          i_rst;
    logic          i_a_valid, i_a_last, o_a_ready;
    logic [DW-1:0] i_a_data;
    logic          i_b_valid, i_b_last, o_b_ready;
    logic [DW-1:0] i_b_data;
    logic          o_valid, o_last, o_src, i_ready;
    logic [DW-1:0] o_data;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_arb_21 #(.DATA_W(DW)) dut (
        .i_clk    (clk),
        .i_rst    (i_rst),
        .i_a_valid(i_a_valid),
        .i_a_data (i_a_data),
        .i_a_last (i_a_last),
        .o_a_ready(o_a_ready),
        .i_b_valid(i_b_valid),
        .i_b_data (i_b_data),
        .i_b_last (i_b_last),
        .o_b_ready(o_b_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_src    (o_src),
        .i_ready  (i_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // owner: -1 no packet in progress, 0 = A holds the output, 1 = B holds it.
    int           owner   = -1;
    bit           m_ls    = 1'b1;   // last served source
    logic         m_vld   = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic         m_last  = 1'b0;
    logic         m_src   = 1'b0;
    bit           started = 1'b0;
    logic [DW:0]  qa[$];
    logic [DW:0]  qb[$];

    // Who may hand over a beat right now, from the arbitration rules.
    function automatic bit exp_ready(input bit x);
        bit free, vx, vo;
        free = !m_vld || i_ready;
        vx   = x ? i_b_valid : i_a_valid;
        vo   = x ? i_a_valid : i_b_valid;
        if (i_rst || !free) return 1'b0;
        if (owner >= 0)     return owner == int'(x);
        if (!vx)            return 1'b0;
        if (vo)             return x != m_ls;
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model
        bit aa, ab, src;
        logic [DW:0] b;
        if (i_rst) begin
            started <= 1'b1;
            owner   <= -1;
            m_ls    <= 1'b1;
            m_vld   <= 1'b0;
            m_data  <= '0;
            m_last  <= 1'b0;
            m_src   <= 1'b0;
            qa.delete();
            qb.delete();
        end else begin
            aa = i_a_valid && exp_ready(1'b0);
            ab = i_b_valid && exp_ready(1'b1);
            if (aa || ab) begin
                src = ab;
                b   = ab ? {i_b_last, i_b_data} : {i_a_last, i_a_data};
                m_vld  <= 1'b1;
                m_data <= b[DW-1:0];
                m_last <= b[DW];
                m_src  <= src;
                if (src) qb.push_back(b);
                else     qa.push_back(b);
                if (b[DW]) begin
                    owner <= -1;
                    m_ls  <= src;
                end else begin
                    owner <= int'(src);
                end
            end else if (i_ready) begin
                m_vld <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int wait_a  = 0;
    int wait_b  = 0;
    int pkt_src = -1;

    always @(negedge clk) begin : cmp
        bit ea, eb, aa, ab;
        logic [DW:0] eb_beat;
        if (started) begin
            ea = exp_ready(1'b0);
            eb = exp_ready(1'b1);
            chk("a_ready", o_a_ready, ea);
            chk("b_ready", o_b_ready, eb);
            chk("o_valid", o_valid, m_vld);
            if (m_vld) begin
                chk("o_data", o_data, m_data);
                chk("o_last", o_last, m_last);
                chk("o_src",  o_src,  m_src);
            end
            if (i_rst) begin
                wait_a  = 0;
                wait_b  = 0;
                pkt_src = -1;
            end else begin
                if (o_valid && i_ready) begin
                    if ((o_src ? qb.size() : qa.size()) == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_extra: src %0d beat %0h not expected", o_src, o_data);
                    end else begin
                        eb_beat = o_src ? qb.pop_front() : qa.pop_front();
                        chk("sb_beat", {o_last, o_data}, eb_beat);
                    end
                    if (pkt_src >= 0) chk("no_interleave", o_src, pkt_src);
                    pkt_src = o_last ? -1 : int'(o_src);
                end
                aa = i_a_valid && ea;
                ab = i_b_valid && eb;
                // A waiting requester may see at most one foreign packet finish.
                if (!i_a_valid || aa) wait_a = 0;
                else if (ab && i_b_last) begin
                    wait_a++;
                    chk("starve_a", wait_a > 1, 0);
                end
                if (!i_b_valid || ab) wait_b = 0;
                else if (aa && i_a_last) begin
                    wait_b++;
                    chk("starve_b", wait_b > 1, 0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [DW-1:0] d, input logic l);
        i_a_valid = v; i_a_data = d; i_a_last = l;
    endtask

    task automatic set_b(input logic v, input logic [DW-1:0] d, input logic l);
        i_b_valid = v; i_b_data = d; i_b_last = l;
    endtask

    task automatic out_is(input string name, input logic [DW-1:0] d, input logic s);
        chk({name, "_vld"}, o_valid, 1'b1);
        chk({name, "_dat"}, o_data, d);
        chk({name, "_src"}, o_src, s);
    endtask

    initial begin
        bit acc_a, acc_b;
        i_rst = 1'b1;
        i_ready = 1'b1;
        set_a(1'b1, 8'h11, 1'b1);
        set_b(1'b1, 8'h22, 1'b1);

        // Reset state, readies held low despite valid requests.
        cyc; cyc; #1;
        chk("rst_o_valid", o_valid, 1'b0);
        chk("rst_o_data",  o_data,  8'h00);
        chk("rst_o_last",  o_last,  1'b0);
        chk("rst_o_src",   o_src,   1'b0);
        chk("rst_a_ready", o_a_ready, 1'b0);
        chk("rst_b_ready", o_b_ready, 1'b0);

        // Alternation of single-beat requests, A first.
        i_rst = 1'b0; #1;
        chk("tie_a_ready", o_a_ready, 1'b1);
        chk("tie_b_ready", o_b_ready, 1'b0);
        cyc; out_is("alt0", 8'h11, 1'b0);
        cyc; out_is("alt1", 8'h22, 1'b1);
        cyc; out_is("alt2", 8'h11, 1'b0);
        cyc; out_is("alt3", 8'h22, 1'b1);

        // Three-beat A packet locks out B.
        set_a(1'b1, 8'hA0, 1'b0); #1;
        chk("pkt_a_ready", o_a_ready, 1'b1);
        chk("pkt_b_ready0", o_b_ready, 1'b0);
        cyc; out_is("pkt0", 8'hA0, 1'b0);
        set_a(1'b1, 8'hA1, 1'b0); #1;
        chk("pkt_b_ready1", o_b_ready, 1'b0);
        cyc; out_is("pkt1", 8'hA1, 1'b0);
        set_a(1'b1, 8'hA2, 1'b1); #1;
        chk("pkt_b_ready2", o_b_ready, 1'b0);
        cyc; out_is("pkt2", 8'hA2, 1'b0);
        chk("pkt2_last", o_last, 1'b1);
        set_a(1'b0, 8'h00, 1'b0); #1;
        chk("pkt_b_after", o_b_ready, 1'b1);
        cyc; out_is("pkt_b", 8'h22, 1'b1);

        // Output stall holds the beat and blocks both requesters.
        set_a(1'b1, 8'h5A, 1'b1);
        set_b(1'b0, 8'h00, 1'b0);
        cyc; out_is("stall_ld", 8'h5A, 1'b0);
        i_ready = 1'b0;
        set_a(1'b1, 8'h66, 1'b1);
        set_b(1'b1, 8'h99, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            out_is("stall", 8'h5A, 1'b0);
            chk("stall_a_ready", o_a_ready, 1'b0);
            chk("stall_b_ready", o_b_ready, 1'b0);
            cyc;
        end
        i_ready = 1'b1;
        set_a(1'b0, 8'h00, 1'b0);
        set_b(1'b0, 8'h00, 1'b0); #1;
        out_is("stall_rel", 8'h5A, 1'b0);
        cyc;
        chk("stall_drained", o_valid, 1'b0);

        // ptr still says A was last: tie now goes to B, which locks.
        set_b(1'b1, 8'hB0, 1'b0);
        set_a(1'b1, 8'h77, 1'b1); #1;
        chk("lockb_b_ready", o_b_ready, 1'b1);
        chk("lockb_a_ready", o_a_ready, 1'b0);
        cyc; out_is("lockb0", 8'hB0, 1'b1);
        set_b(1'b0, 8'h00, 1'b0); #1;
        chk("lockb_hold_a0", o_a_ready, 1'b0);
        cyc;
        chk("lockb_gap0", o_valid, 1'b0);
        chk("lockb_hold_a1", o_a_ready, 1'b0);
        cyc;
        chk("lockb_gap1", o_valid, 1'b0);
        set_b(1'b1, 8'hB1, 1'b1); #1;
        chk("lockb_hold_a2", o_a_ready, 1'b0);
        cyc; out_is("lockb1", 8'hB1, 1'b1);
        set_b(1'b0, 8'h00, 1'b0); #1;
        chk("lockb_then_a", o_a_ready, 1'b1);
        cyc; out_is("lockb_a", 8'h77, 1'b0);

        // Reset in the middle of an A packet.
        set_a(1'b1, 8'hC0, 1'b0);
        cyc; out_is("rstpkt0", 8'hC0, 1'b0);
        set_a(1'b1, 8'hC1, 1'b0);
        set_b(1'b1, 8'h44, 1'b1);
        i_rst = 1'b1; #1;
        chk("mid_rst_a_ready", o_a_ready, 1'b0);
        chk("mid_rst_b_ready", o_b_ready, 1'b0);
        cyc;
        chk("mid_rst_o_valid", o_valid, 1'b0);
        i_rst = 1'b0;
        set_a(1'b1, 8'hD0, 1'b1); #1;
        chk("post_rst_o_valid", o_valid, 1'b0);
        chk("post_rst_a_ready", o_a_ready, 1'b1);
        chk("post_rst_b_ready", o_b_ready, 1'b0);
        cyc; out_is("post_rst", 8'hD0, 1'b0);

        // Randomized traffic; a valid beat is held until it is accepted.
        set_a(1'b0, 8'h00, 1'b0);
        set_b(1'b0, 8'h00, 1'b0);
        acc_a = 1'b0;
        acc_b = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            if (!i_a_valid || acc_a) begin
                if ($urandom_range(0, 99) < 60)
                    set_a(1'b1, DW'($urandom), $urandom_range(0, 2) == 0);
                else
                    set_a(1'b0, 8'h00, 1'b0);
            end
            if (!i_b_valid || acc_b) begin
                if ($urandom_range(0, 99) < 60)
                    set_b(1'b1, DW'($urandom), $urandom_range(0, 2) == 0);
                else
                    set_b(1'b0, 8'h00, 1'b0);
            end
            i_ready = $urandom_range(0, 99) < 70;
            i_rst   = $urandom_range(0, 1999) == 0;
            #1;
            acc_a = i_a_valid && o_a_ready;
            acc_b = i_b_valid && o_b_ready;
            cyc;
        end
        i_rst = 1'b0;
        i_ready = 1'b1;
        set_a(1'b0, 8'h00, 1'b0);
        set_b(1'b0, 8'h00, 1'b0);
        cyc; cyc; cyc;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_arb_21.md
RR_ARB_21 -- requirements
Module: rr_arb_21

Interface
REQ-001 Parameter: DATA_W, 8, width of every data path.
REQ-002 Ports SHALL be exactly (name direction width meaning):
- i_clk  in  1  sole clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_a_valid  in  1  requester A beat valid.
- i_a_data  in  DATA_W  requester A beat data.
- i_a_last  in  1  requester A final beat of packet.
- o_a_ready  out  1  requester A beat accepted this cycle when high with i_a_valid.
- i_b_valid / i_b_data / i_b_last / o_b_ready  same widths and meanings for requester B.
- o_valid  out  1  output beat valid.
- o_data  out  DATA_W  output beat data.
- o_last  out  1  output beat is final beat of packet.
- o_src  out  1  source of output beat: 0 = A, 1 = B.
- i_ready  in  1  downstream accepts output beat when high with o_valid.
REQ-003 One clock; reset is synchronous and active-high; no other clocks or async inputs.

Function
REQ-010 Handshake: a beat transfers on a rising edge where valid and ready are both high; once asserted, o_valid SHALL hold, with o_data/o_last/o_src stable, until i_ready transfers it.
REQ-011 slot_free = !o_valid || i_ready; requester ready is never asserted while slot_free is low.
REQ-012 Output is one register stage: an accepted input beat appears on o_valid/o_data/o_last/o_src exactly 1 cycle later; sustained throughput 1 beat/cycle with i_ready held high.
REQ-013 State machine states: IDLE, LOCK_A, LOCK_B.
REQ-014 Priority pointer ptr (1 bit, last-served source); in IDLE, grant A if only A valid, B if only B valid, and when both valid grant the source != ptr.
REQ-015 IDLE: o_x_ready = slot_free && grant_x; at most one of o_a_ready/o_b_ready high in any cycle.
REQ-016 IDLE, beat from x accepted with last=1: stay IDLE, ptr <= x.
REQ-017 IDLE, beat from x accepted with last=0: go LOCK_x; ptr unchanged.
REQ-018 LOCK_x: o_x_ready = slot_free; other requester's ready SHALL be 0 regardless of its valid.
REQ-019 LOCK_x, beat accepted with last=1: go IDLE, ptr <= x; last=0: stay LOCK_x.
REQ-020 LOCK_x with i_x_valid low: hold lock, no beat accepted, other requester stalls.
REQ-021 Output slot full and i_ready low: no acceptance, no state or ptr change.
REQ-022 Ready SHALL depend combinationally only on state, ptr, o_valid, i_ready and input valids; never on input data or last.
REQ-023 o_data is a pure copy of the selected input data; no width change or arithmetic.

Reset
REQ-030 While i_rst high at a clock edge: o_valid=0, o_data=0, o_last=0, o_src=0, state=IDLE, ptr=1 (A wins the first tie).
REQ-031 o_a_ready and o_b_ready SHALL be 0 in any cycle i_rst is high.
REQ-032 Reset mid-packet SHALL drop the lock and discard any pending output beat; no beat is emitted in the cycle after reset deasserts.

Verification
REQ-040 Reset then A and B both valid, single-beat (last=1), A=8'h11, B=8'h22, i_ready=1 -> outputs 8'h11 src0, 8'h22 src1, alternating while both stay valid.
REQ-041 A sends 3-beat packet 8'hA0,8'hA1,8'hA2 (last on third) with B valid throughout -> o_data A0,A1,A2 src0 consecutive, o_b_ready=0 until A2 accepted, then B beat next.
REQ-042 i_ready held 0 for 4 cycles with o_valid=1, o_data=8'h5A -> o_data stays 8'h5A, both readies 0, state and ptr unchanged; single beat out when i_ready rises.
REQ-043 LOCK_B entered, i_b_valid dropped 2 cycles while A valid -> no output beat, o_a_ready=0; B resumes and completes packet, then A served.
REQ-044 i_rst pulsed during a LOCK_A packet after 1 of 3 beats -> o_valid=0 after reset, state IDLE, simultaneous A/B request then grants A.
REQ-045 Random valid/last/i_ready, 10k cycles -> scoreboard per source: no loss, duplication or reordering; packets never interleaved on output; no requester starved beyond one packet while the other is granted.
